// File: rtl/eh2_dec_gpr_wbq_pkg.sv
// -----------------------------------------------------------------------------
// eh2_dec_gpr_wbq_pkg
// Shared types and constants for the GPR port-3 writeback queue.
//   WBQ_DEPTH        : default number of queue entries
//   eh2_wbq_entry_t  : one queue slot {valid, killed, tid, waddr, data}
//   wbq_mk_entry()   : builds a live, unkilled entry from a push request
// -----------------------------------------------------------------------------
package eh2_dec_gpr_wbq_pkg;

   localparam int WBQ_DEPTH = 4;

   typedef struct packed {
      logic        valid;
      logic        killed;
      logic        tid;
      logic [4:0]  waddr;
      logic [31:0] data;
   } eh2_wbq_entry_t;

   function automatic eh2_wbq_entry_t wbq_mk_entry(input logic        tid,
                                                   input logic [4:0]  waddr,
                                                   input logic [31:0] data);
      eh2_wbq_entry_t e;
      e.valid  = 1'b1;
      e.killed = 1'b0;
      e.tid    = tid;
      e.waddr  = waddr;
      e.data   = data;
      return e;
   endfunction

endpackage

// File: rtl/eh2_dec_gpr_wbq.sv
// -----------------------------------------------------------------------------
// eh2_dec_gpr_wbq
// Writeback queue in front of GPR write port 3. Load returns and divider
// results are buffered and drained in order whenever the pipeline leaves
// port 3 idle. A per-thread pending vector lets decode stall dependent reads.
//
// Ports:
//   clk, rst_l                 : clock, asynchronous active-low reset
//   ld_valid/tid/waddr/data    : load-return push, ld_ready back
//   div_valid/tid/waddr/data   : divider push, div_ready back
//   port_free                  : port 3 is idle this cycle
//   flush[1:0]                 : per-thread kill of queued entries
//   wen3/wtid3/waddr3/wd3      : GPR port 3 write
//   pending[t][r]              : thread t has a live queued write to r
//   full, empty                : occupancy status
//
// Handshake: a push is taken on any cycle where valid=1; the source must only
// raise valid while the matching ready is 1. Both readies are computed from
// the registered count alone, so they never depend on this cycle's valid,
// pop or flush. div_ready demands two free slots so a load and a divider
// result arriving together always fit.
//
// Optional feature: define RV_GPR_WBQ_BYPASS_EN to let a load return write
// port 3 in its own cycle when the queue is empty and the port is free.
// -----------------------------------------------------------------------------
module eh2_dec_gpr_wbq
   import eh2_dec_gpr_wbq_pkg::*;
#(
   parameter int DEPTH = WBQ_DEPTH
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              ld_valid,
   input  logic              ld_tid,
   input  logic [4:0]        ld_waddr,
   input  logic [31:0]       ld_data,
   output logic              ld_ready,
   input  logic              div_valid,
   input  logic              div_tid,
   input  logic [4:0]        div_waddr,
   input  logic [31:0]       div_data,
   output logic              div_ready,
   input  logic              port_free,
   input  logic [1:0]        flush,
   output logic              wen3,
   output logic              wtid3,
   output logic [4:0]        waddr3,
   output logic [31:0]       wd3,
   output logic [1:0][31:1]  pending,
   output logic              full,
   output logic              empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   eh2_wbq_entry_t entries [DEPTH];
   logic [PW-1:0]  head;
   logic [PW-1:0]  tail;
   logic [CW-1:0]  count;
   logic [CW-1:0]  free;

   eh2_wbq_entry_t head_e;
   logic           head_kill;
   logic           pop;
   logic           q_wen;
   logic           bypass;
   logic           ld_store;
   logic           div_store;
   logic [1:0]     n_push;
   logic [PW-1:0]  div_slot;

   assign free      = CW'(DEPTH) - count;
   assign ld_ready  = (free >= CW'(1));
   assign div_ready = (free >= CW'(2));
   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);

   // A flush landing on the head this cycle turns its pop into a silent retire.
   assign head_e    = entries[head];
   assign head_kill = head_e.killed | flush[head_e.tid];
   assign pop       = head_e.valid & (port_free | head_kill);
   assign q_wen     = head_e.valid & ~head_kill & port_free;

`ifdef RV_GPR_WBQ_BYPASS_EN
   assign bypass = empty & port_free & ld_valid & (ld_waddr != 5'd0) & ~flush[ld_tid];
`else
   assign bypass = 1'b0;
`endif

   // x0 writes and pushes killed by a same-cycle flush never take a slot.
   assign ld_store  = ld_valid & ld_ready & (ld_waddr != 5'd0) & ~flush[ld_tid] & ~bypass;
   assign div_store = div_valid & div_ready & (div_waddr != 5'd0) & ~flush[div_tid];
   assign n_push    = {1'b0, ld_store} + {1'b0, div_store};
   assign div_slot  = tail + PW'(ld_store);

   always_comb begin
      wen3   = 1'b0;
      wtid3  = 1'b0;
      waddr3 = 5'd0;
      wd3    = 32'd0;
      if (bypass) begin
         wen3   = 1'b1;
         wtid3  = ld_tid;
         waddr3 = ld_waddr;
         wd3    = ld_data;
      end else if (q_wen) begin
         wen3   = 1'b1;
         wtid3  = head_e.tid;
         waddr3 = head_e.waddr;
         wd3    = head_e.data;
      end
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entries[i].valid && !entries[i].killed && (entries[i].waddr != 5'd0)) begin
            pending[entries[i].tid][entries[i].waddr] = 1'b1;
         end
      end
   end

   // Later assignments win: a pop clears the head slot after any kill mark,
   // and a push can only target a slot that is currently free.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid && flush[entries[i].tid]) begin
               entries[i].killed <= 1'b1;
            end
         end
         if (pop) begin
            entries[head] <= '0;
         end
         if (ld_store) begin
            entries[tail] <= wbq_mk_entry(ld_tid, ld_waddr, ld_data);
         end
         if (div_store) begin
            entries[div_slot] <= wbq_mk_entry(div_tid, div_waddr, div_data);
         end
         head  <= head + PW'(pop);
         tail  <= tail + PW'(n_push);
         count <= count + CW'(n_push) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_eh2_dec_gpr_wbq.sv
module tb_eh2_dec_gpr_wbq;

   logic              clk;
   logic              rst_l;
   logic              ld_valid;
   logic              ld_tid;
   logic [4:0]        ld_waddr;
   logic [31:0]       ld_data;
   logic              ld_ready;
   logic              div_valid;
   logic              div_tid;
   logic [4:0]        div_waddr;
   logic [31:0]       div_data;
   logic              div_ready;
   logic              port_free;
   logic [1:0]        flush;
   logic              wen3;
   logic              wtid3;
   logic [4:0]        waddr3;
   logic [31:0]       wd3;
   logic [1:0][31:1]  pending;
   logic              full;
   logic              empty;

   eh2_dec_gpr_wbq #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst_l     (rst_l),
      .ld_valid  (ld_valid),
      .ld_tid    (ld_tid),
      .ld_waddr  (ld_waddr),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .div_valid (div_valid),
      .div_tid   (div_tid),
      .div_waddr (div_waddr),
      .div_data  (div_data),
      .div_ready (div_ready),
      .port_free (port_free),
      .flush     (flush),
      .wen3      (wen3),
      .wtid3     (wtid3),
      .waddr3    (waddr3),
      .wd3       (wd3),
      .pending   (pending),
      .full      (full),
      .empty     (empty)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- vector table ----------------
   typedef struct {
      logic        lv;
      logic        lt;
      logic [4:0]  la;
      logic [31:0] ld;
      logic        dv;
      logic        dt;
      logic [4:0]  da;
      logic [31:0] dd;
      logic        pf;
      logic [1:0]  fl;
      logic        e_wen;
      logic        e_tid;
      logic [4:0]  e_addr;
      logic [31:0] e_wd;
      logic [61:0] e_pend;
      logic        e_full;
      logic        e_empty;
      logic        e_ldr;
      logic        e_dvr;
   } vec_t;

   vec_t tbl[$];
   logic [37:0] exp_q[$];
   int checks;
   int errors;

   function automatic logic [61:0] pb(input int t, input int r);
      logic [61:0] v;
      v = '0;
      v[t*31 + r - 1] = 1'b1;
      return v;
   endfunction

   function automatic vec_t row(input logic lv, input logic lt, input logic [4:0] la, input logic [31:0] ld,
                                input logic dv, input logic dt, input logic [4:0] da, input logic [31:0] dd,
                                input logic pf, input logic [1:0] fl,
                                input logic ew, input logic et, input logic [4:0] ea, input logic [31:0] ed,
                                input logic [61:0] ep, input logic ef, input logic ee,
                                input logic elr, input logic edr);
      vec_t v;
      v.lv = lv; v.lt = lt; v.la = la; v.ld = ld;
      v.dv = dv; v.dt = dt; v.da = da; v.dd = dd;
      v.pf = pf; v.fl = fl;
      v.e_wen = ew; v.e_tid = et; v.e_addr = ea; v.e_wd = ed;
      v.e_pend = ep; v.e_full = ef; v.e_empty = ee; v.e_ldr = elr; v.e_dvr = edr;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_idle(input logic pf);
      ld_valid  = 1'b0; ld_tid  = 1'b0; ld_waddr  = 5'd0; ld_data  = 32'd0;
      div_valid = 1'b0; div_tid = 1'b0; div_waddr = 5'd0; div_data = 32'd0;
      flush     = 2'b00;
      port_free = pf;
   endtask

   task automatic drive_ld(input logic t, input logic [4:0] a, input logic [31:0] d);
      ld_valid = 1'b1; ld_tid = t; ld_waddr = a; ld_data = d;
   endtask

   task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: actual %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // One cycle: apply inputs at the falling edge, compare just after.
   task automatic apply_row(input int idx, input vec_t v);
      @(negedge clk);
      drive_idle(v.pf);
      ld_valid = v.lv;  ld_tid = v.lt;  ld_waddr = v.la;  ld_data = v.ld;
      div_valid = v.dv; div_tid = v.dt; div_waddr = v.da; div_data = v.dd;
      flush = v.fl;
      #1;
      check("wen3",      idx, 64'(wen3),      64'(v.e_wen));
      check("wtid3",     idx, 64'(wtid3),     64'(v.e_tid));
      check("waddr3",    idx, 64'(waddr3),    64'(v.e_addr));
      check("wd3",       idx, 64'(wd3),       64'(v.e_wd));
      check("pending",   idx, 64'(pending),   64'(v.e_pend));
      check("full",      idx, 64'(full),      64'(v.e_full));
      check("empty",     idx, 64'(empty),     64'(v.e_empty));
      check("ld_ready",  idx, 64'(ld_ready),  64'(v.e_ldr));
      check("div_ready", idx, 64'(div_ready), 64'(v.e_dvr));
   endtask

   // Pushes one load with random data and records the expected write.
   task automatic push_ld_rand(input logic t, input logic [4:0] a, input logic pf);
      logic [31:0] d;
      d = $urandom_range(32'h7fff_ffff, 0);
      @(negedge clk);
      drive_idle(pf);
      drive_ld(t, a, d);
      exp_q.push_back({t, a, d});
   endtask

   // Checks the port-3 write against the head of the expected queue.
   task automatic expect_write(input string name, input int idx);
      logic [37:0] e;
      check({name, "_wen3"}, idx, 64'(wen3), 64'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({name, "_write"}, idx, 64'({wtid3, waddr3, wd3}), 64'(e));
      end else begin
         check({name, "_queue_underrun"}, idx, 64'(exp_q.size()), 64'd1);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      drive_idle(1'b0);
      rst_l = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_l = 1'b1;

      //        lv lt la    ld            dv dt da    dd            pf fl     ew et ea    ed            pend                    f  e  lr dr
      tbl.push_back(row(0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,   0, 2'b00, 0, 0, 5'd0, 32'h0,        62'h0,                  0, 1, 1, 1));
      tbl.push_back(row(1, 0, 5'd5, 32'h12345678, 0, 0, 5'd0, 32'h0,   1, 2'b00, 0, 0, 5'd0, 32'h0,        62'h0,                  0, 1, 1, 1));
      tbl.push_back(row(0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,   1, 2'b00, 1, 0, 5'd5, 32'h12345678, pb(0,5),                0, 0, 1, 1));
      tbl.push_back(row(0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,   1, 2'b00, 0, 0, 5'd0, 32'h0,        62'h0,                  0, 1, 1, 1));
      tbl.push_back(row(1, 1, 5'd7, 32'hA,        1, 1, 5'd7, 32'hB,   0, 2'b00, 0, 0, 5'd0, 32'h0,        62'h0,                  0, 1, 1, 1));
      tbl.push_back(row(0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,   1, 2'b00, 1, 1, 5'd7, 32'hA,        pb(1,7),                0, 0, 1, 1));
      tbl.push_back(row(0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,   1, 2'b00, 1, 1, 5'd7, 32'hB,        pb(1,7),                0, 0, 1, 1));
      tbl.push_back(row(0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,   0, 2'b00, 0, 0, 5'd0, 32'h0,        62'h0,                  0, 1, 1, 1));
      tbl.push_back(row(1, 0, 5'd3, 32'h33,       1, 1, 5'd4, 32'h44,  0, 2'b00, 0, 0, 5'd0, 32'h0,        62'h0,                  0, 1, 1, 1));
      tbl.push_back(row(0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,   1, 2'b01, 0, 0, 5'd0, 32'h0,        pb(0,3) | pb(1,4),      0, 0, 1, 1));
      tbl.push_back(row(0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,   1, 2'b00, 1, 1, 5'd4, 32'h44,       pb(1,4),                0, 0, 1, 1));
      tbl.push_back(row(0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,   0, 2'b00, 0, 0, 5'd0, 32'h0,        62'h0,                  0, 1, 1, 1));
      tbl.push_back(row(1, 0, 5'd3, 32'h55,       1, 1, 5'd9, 32'h99,  0, 2'b00, 0, 0, 5'd0, 32'h0,        62'h0,                  0, 1, 1, 1));
      tbl.push_back(row(0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,   0, 2'b10, 0, 0, 5'd0, 32'h0,        pb(0,3) | pb(1,9),      0, 0, 1, 1));
      tbl.push_back(row(0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,   0, 2'b00, 0, 0, 5'd0, 32'h0,        pb(0,3),                0, 0, 1, 1));
      tbl.push_back(row(0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,   1, 2'b00, 1, 0, 5'd3, 32'h55,       pb(0,3),                0, 0, 1, 1));
      tbl.push_back(row(0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,   0, 2'b00, 0, 0, 5'd0, 32'h0,        62'h0,                  0, 0, 1, 1));
      tbl.push_back(row(1, 1, 5'd6, 32'h66,       0, 0, 5'd0, 32'h0,   0, 2'b10, 0, 0, 5'd0, 32'h0,        62'h0,                  0, 1, 1, 1));
      tbl.push_back(row(1, 0, 5'd0, 32'h77,       1, 1, 5'd0, 32'h88,  1, 2'b00, 0, 0, 5'd0, 32'h0,        62'h0,                  0, 1, 1, 1));
      tbl.push_back(row(0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,   1, 2'b00, 0, 0, 5'd0, 32'h0,        62'h0,                  0, 1, 1, 1));

      for (int i = 0; i < tbl.size(); i++) begin
         apply_row(i, tbl[i]);
      end

      // Fill to DEPTH with the port busy, watching the ready thresholds.
      for (int k = 0; k < 4; k++) begin
         push_ld_rand(1'(k), 5'(10 + k), 1'b0);
         #1;
         check("fill_ld_ready",  k, 64'(ld_ready),  64'd1);
         check("fill_div_ready", k, 64'(div_ready), 64'(k <= 2));
         check("fill_full",      k, 64'(full),      64'd0);
      end
      @(negedge clk);
      drive_idle(1'b0);
      #1;
      check("full_full",      0, 64'(full),      64'd1);
      check("full_ld_ready",  0, 64'(ld_ready),  64'd0);
      check("full_div_ready", 0, 64'(div_ready), 64'd0);
      check("full_wen3",      0, 64'(wen3),      64'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drive_idle(1'b1);
         #1;
         expect_write("drain", k);
      end
      @(negedge clk);
      drive_idle(1'b0);
      #1;
      check("drain_empty", 0, 64'(empty), 64'd1);
      check("drain_wen3",  0, 64'(wen3),  64'd0);

      // Push and pop together at DEPTH-1: occupancy must hold at three.
      for (int k = 0; k < 3; k++) begin
         push_ld_rand(1'b0, 5'(20 + k), 1'b0);
      end
      push_ld_rand(1'b1, 5'd31, 1'b1);
      #1;
      expect_write("pp_pop", 0);
      @(negedge clk);
      drive_idle(1'b0);
      #1;
      check("pp_ld_ready",  0, 64'(ld_ready),  64'd1);
      check("pp_div_ready", 0, 64'(div_ready), 64'd0);
      check("pp_full",      0, 64'(full),      64'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive_idle(1'b1);
         #1;
         expect_write("pp_drain", k);
      end
      @(negedge clk);
      drive_idle(1'b0);
      #1;
      check("pp_empty", 0, 64'(empty), 64'd1);

      // Reset mid-drain drops everything at once.
      for (int k = 0; k < 3; k++) begin
         push_ld_rand(1'b0, 5'(1 + k), 1'b0);
      end
      @(negedge clk);
      drive_idle(1'b1);
      #1;
      expect_write("rst_pre", 0);
      #1;
      rst_l = 1'b0;
      #1;
      check("rst_wen3",      0, 64'(wen3),      64'd0);
      check("rst_waddr3",    0, 64'(waddr3),    64'd0);
      check("rst_wd3",       0, 64'(wd3),       64'd0);
      check("rst_pending",   0, 64'(pending),   64'd0);
      check("rst_empty",     0, 64'(empty),     64'd1);
      check("rst_full",      0, 64'(full),      64'd0);
      check("rst_ld_ready",  0, 64'(ld_ready),  64'd1);
      check("rst_div_ready", 0, 64'(div_ready), 64'd1);
      exp_q.delete();
      @(negedge clk);
      rst_l = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive_idle(1'b1);
         #1;
         check("post_rst_wen3", k, 64'(wen3), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/eh2_dec_gpr_wbq.md
# eh2_dec_gpr_wbq

Writeback queue feeding GPR write port 3 of the decode-stage register file. It buffers out-of-pipe results from non-blocking load returns and the divider. Buffered entries drain in order whenever the pipeline leaves port 3 idle. It also publishes a per-thread pending-write vector that decode uses to stall dependent reads.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.

Ports:
- clk  in  1  core clock.
- rst_l  in  1  reset; asynchronous, active-low.
- ld_valid  in  1  load-return push request.
- ld_tid  in  1  load-return thread.
- ld_waddr  in  5  load-return destination register.
- ld_data  in  32  load-return data.
- ld_ready  out  1  queue can accept a load push this cycle.
- div_valid  in  1  divider push request.
- div_tid  in  1  divider thread.
- div_waddr  in  5  divider destination register.
- div_data  in  32  divider result.
- div_ready  out  1  queue can accept a divider push this cycle.
- port_free  in  1  pipeline is not using GPR write port 3 this cycle.
- flush  in  2  per-thread kill of queued entries.
- wen3  out  1  write enable to GPR port 3.
- wtid3  out  1  write thread.
- waddr3  out  5  write address.
- wd3  out  32  write data.
- pending  out  2x31  [t][r] set when thread t has a queued, unkilled write to register r (r = 1..31).
- full  out  1  every entry is occupied.
- empty  out  1  no entry is occupied.

## Operation
- Storage is a circular buffer with head/tail pointers and count (width clog2(DEPTH)+1). Each entry holds valid, killed, tid, waddr, data.
- Push acceptance:
  - ld_ready = free ≥ 1.
  - div_ready = free ≥ 2.
  - free is derived from the registered count only. It does not depend on valid or pop.
  - Pushing while not ready is illegal.
- A load and a divider push in the same cycle are both written: load at tail, divider at tail+1.
- A push with waddr 0 is accepted but not stored. It consumes no entry and sets no pending bit.
- Pop: the head entry pops when it is valid and either port_free=1 or the entry is killed.
  - Unkilled entry: the pop asserts wen3 with the entry's tid/waddr/data.
  - Killed entry: the pop keeps wen3=0 and retires the entry in one cycle.
- Flush: flush[t]=1 sets killed on every valid entry with tid t. A same-cycle push with tid t is dropped, not stored.
- pending[t][r] is the OR over valid, unkilled entries with tid t and waddr r.
- Same thread and register queued twice: FIFO order guarantees the youngest value is written last.
- Reset: all entries invalid, pointers 0, count 0. Outputs: wen3=0, wtid3=0, waddr3=0, wd3=0, pending=0, full=0, empty=1, ld_ready=1, div_ready=1.

## Timing
- Push in cycle N: the entry is visible at head and in pending at N+1.
- Earliest wen3 is N+1, when port_free=1 at N+1. wen3/waddr3/wd3 are combinational from head state and port_free.
- Sustained throughput is one pop per cycle.
- Simultaneous push and pop when count=DEPTH-1: legal; count is unchanged.
- Flush in the same cycle the head pops with matching tid: the pop is suppressed to killed (wen3=0).
- Pointers wrap modulo DEPTH.
- Reset asserted mid-drain discards all entries immediately (asynchronous).

## Configuration
- RV_GPR_WBQ_BYPASS_EN, when defined:
  - Condition: empty=1, port_free=1, ld_valid=1, ld_waddr≠0, flush[ld_tid]=0.
  - Effect: the load result drives wen3/wtid3/waddr3/wd3 in the same cycle and is not stored.
  - If a divider push arrives in the same cycle, the divider entry is still stored.
- Without the macro, every result passes through an entry. Minimum latency is 1 cycle.

## Structure
- Shared package eh2_pkg receives typedef eh2_wbq_entry_t {valid, killed, tid, waddr[4:0], data[31:0]}.
- eh2_param_pkg receives constant WBQ_DEPTH = 4.
- No sub-module. Entry registers use rvdffe gated on push or kill; pointers and count use rvdff.

## Test plan
- Load push r5=0x1234_5678, tid 0, port_free=1: wen3=1, waddr3=5, wd3=0x12345678 at N+1 (same cycle with bypass); pending[0][5] is 1 for one cycle.
- Fill 4 entries with port_free=0: full=1, ld_ready=0, div_ready=0. Raise port_free: 4 writes in FIFO order on consecutive cycles, then empty=1.
- Same-cycle load r7=0xA and divide r7=0xB, tid 1: writes 0xA then 0xB; pending[1][7] clears after the second pop.
- Queue tid0 r3 and tid1 r4, assert flush[0]: tid0 entry pops with wen3=0, tid1 r4 then writes; pending[0]=0 from the next cycle.
- Push waddr 0: no entry stored; empty stays 1; wen3 never asserts.
- Assert rst_l low with 3 queued entries: outputs return to reset values asynchronously; no write occurs after release.
